// File: rtl/tpu_pkg.sv
// Shared definitions for the VPU-to-unified-buffer datapath.
//   DATA_W     : width of one VPU lane element
//   LANES      : number of VPU lanes packed into one UB row word
//   elem_t     : signed lane element, passed through unmodified
//   wb_state_t : write-back controller states
package tpu_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;

  typedef logic signed [DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/vpu_ub_writeback_if.sv
// Unified-buffer write port: one row word per valid/ready handshake.
//   ub_wr_valid : row word presented (driven by the write-back master)
//   ub_wr_ready : UB accepts the word when valid && ready
//   ub_wr_addr  : UB word address
//   ub_wr_data  : packed row, lane 1 in the low bits
interface vpu_ub_writeback_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = tpu_pkg::LANES * tpu_pkg::DATA_W
) ();

  logic              ub_wr_valid;
  logic              ub_wr_ready;
  logic [ADDR_W-1:0] ub_wr_addr;
  logic [WORD_W-1:0] ub_wr_data;

  modport master (
    output ub_wr_valid,
    output ub_wr_addr,
    output ub_wr_data,
    input  ub_wr_ready
  );

  modport slave (
    input  ub_wr_valid,
    input  ub_wr_addr,
    input  ub_wr_data,
    output ub_wr_ready
  );

endinterface

// File: rtl/wb_lane_fifo.sv
// Per-lane de-skew FIFO, synchronous, first-word-fall-through head.
//   clk, rst : clock and synchronous active-high reset
//   flush    : empties the FIFO; wins over push and pop
//   push/din : write din when not full, or when full but popping this cycle
//   pop      : remove the head (ignored when empty)
//   dout     : current head, combinational from storage
//   empty    : no entries held
//   full     : FIFO_D entries held
module wb_lane_fifo #(
  parameter int DATA_W = 16,
  parameter int FIFO_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + 1);

  logic [DATA_W-1:0] mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_D));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vpu_ub_writeback.sv
// VPU write-back: re-aligns the four skewed VPU lane streams and writes one
// packed row word per handshake into the unified buffer.
//   clk, rst          : clock, synchronous active-high reset
//   wb_start          : command pulse, accepted only in IDLE
//   wb_base_addr      : UB address of row 0 (latched on accepted start)
//   wb_num_rows       : rows to write (latched on accepted start)
//   vpu_data_in_1..4  : lane elements; lane k lags lane 1 by k-1 cycles
//   vpu_valid_in_1..4 : per-lane valid, no backpressure toward the VPU
//   ub                : UB write port (master side, registered outputs)
//   wb_busy           : high while in RUN
//   wb_done           : 1-cycle pulse after the last row is accepted
//   wb_overflow_err   : sticky, set on a push into a full lane FIFO
module vpu_ub_writeback
  import tpu_pkg::*;
#(
  parameter int FIFO_D = 8,
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_start,
  input  logic [ADDR_W-1:0]   wb_base_addr,
  input  logic [ROW_W-1:0]    wb_num_rows,
  input  elem_t               vpu_data_in_1,
  input  elem_t               vpu_data_in_2,
  input  elem_t               vpu_data_in_3,
  input  elem_t               vpu_data_in_4,
  input  logic                vpu_valid_in_1,
  input  logic                vpu_valid_in_2,
  input  logic                vpu_valid_in_3,
  input  logic                vpu_valid_in_4,
  vpu_ub_writeback_if.master  ub,
  output logic                wb_busy,
  output logic                wb_done,
  output logic                wb_overflow_err
);

  localparam int WORD_W = LANES * DATA_W;

  wb_state_t         state;
  wb_state_t         state_next;

  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  rows_q;
  logic [ROW_W-1:0]  row_idx;   // rows handed off to the UB
  logic [ROW_W-1:0]  pop_cnt;   // rows moved into the output slot
  logic              zero_done_q;
  logic              ovf_q;

  elem_t             lane_din   [LANES];
  elem_t             lane_dout  [LANES];
  logic [LANES-1:0]  lane_vld;
  logic [LANES-1:0]  lane_push;
  logic [LANES-1:0]  lane_empty;
  logic [LANES-1:0]  lane_full;
  logic [WORD_W-1:0] row_word;

  logic              start_accept;
  logic              handshake;
  logic              last_handshake;
  logic              slot_free;
  logic              pop_all;
  logic              fifo_flush;
  logic              ovf_hit;

  assign lane_din[0] = vpu_data_in_1;
  assign lane_din[1] = vpu_data_in_2;
  assign lane_din[2] = vpu_data_in_3;
  assign lane_din[3] = vpu_data_in_4;
  assign lane_vld    = {vpu_valid_in_4, vpu_valid_in_3, vpu_valid_in_2, vpu_valid_in_1};

  assign start_accept   = (state == WB_IDLE) && wb_start && (wb_num_rows != '0);
  assign handshake      = ub.ub_wr_valid && ub.ub_wr_ready;
  assign last_handshake = handshake && (row_idx == rows_q - ROW_W'(1));
  assign slot_free      = !ub.ub_wr_valid || ub.ub_wr_ready;
  assign lane_push      = (state == WB_RUN) ? lane_vld : '0;
  // pop_cnt caps issue at num_rows, so surplus lane data is never written.
  assign pop_all        = (state == WB_RUN) && !(|lane_empty) && slot_free &&
                          (pop_cnt != rows_q);
  assign ovf_hit        = |(lane_push & lane_full & ~{LANES{pop_all}});
  // Flushing while in DONE empties the FIFOs on the edge that returns to IDLE.
  assign fifo_flush     = (state == WB_DONE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wb_lane_fifo #(
      .DATA_W (DATA_W),
      .FIFO_D (FIFO_D)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (lane_push[g]),
      .pop   (pop_all),
      .din   (lane_din[g]),
      .dout  (lane_dout[g]),
      .empty (lane_empty[g]),
      .full  (lane_full[g])
    );
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    row_word = '0;
    for (int i = 0; i < LANES; i++) begin
      row_word[i*DATA_W +: DATA_W] = lane_dout[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE: if (start_accept)   state_next = WB_RUN;
      WB_RUN:  if (last_handshake) state_next = WB_DONE;
      WB_DONE:                     state_next = WB_IDLE;
      default:                     state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q         <= '0;
      rows_q         <= '0;
      row_idx        <= '0;
      pop_cnt        <= '0;
      zero_done_q    <= 1'b0;
      ovf_q          <= 1'b0;
      ub.ub_wr_valid <= 1'b0;
      ub.ub_wr_addr  <= '0;
      ub.ub_wr_data  <= '0;
    end else begin
      // A zero-row command completes immediately without entering RUN.
      zero_done_q <= (state == WB_IDLE) && wb_start && (wb_num_rows == '0);

      if (start_accept) begin
        base_q  <= wb_base_addr;
        rows_q  <= wb_num_rows;
        row_idx <= '0;
        pop_cnt <= '0;
      end else begin
        if (handshake) row_idx <= row_idx + ROW_W'(1);
        if (pop_all)   pop_cnt <= pop_cnt + ROW_W'(1);
      end

      if (ovf_hit) ovf_q <= 1'b1;

      // Rows leave in order with at most one in the slot, so the index of
      // the row being loaded equals the count of rows popped so far.
      if (pop_all) begin
        ub.ub_wr_valid <= 1'b1;
        ub.ub_wr_data  <= row_word;
        ub.ub_wr_addr  <= base_q + ADDR_W'(pop_cnt);
      end else if (handshake) begin
        ub.ub_wr_valid <= 1'b0;
      end
    end
  end

  assign wb_busy         = (state == WB_RUN);
  assign wb_done         = (state == WB_DONE) || zero_done_q;
  assign wb_overflow_err = ovf_q;

endmodule

// File: tb/tb_vpu_ub_writeback.sv
module tb_vpu_ub_writeback;
  import tpu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int ROW_W  = 8;
  localparam int FIFO_D = 8;
  localparam int WORD_W = LANES * DATA_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_start;
  logic [ADDR_W-1:0] wb_base_addr;
  logic [ROW_W-1:0]  wb_num_rows;
  elem_t             vd [LANES];
  logic              vv [LANES];
  logic              wb_busy;
  logic              wb_done;
  logic              wb_overflow_err;

  vpu_ub_writeback_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) ub ();

  vpu_ub_writeback #(
    .FIFO_D (FIFO_D),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_start        (wb_start),
    .wb_base_addr    (wb_base_addr),
    .wb_num_rows     (wb_num_rows),
    .vpu_data_in_1   (vd[0]),
    .vpu_data_in_2   (vd[1]),
    .vpu_data_in_3   (vd[2]),
    .vpu_data_in_4   (vd[3]),
    .vpu_valid_in_1  (vv[0]),
    .vpu_valid_in_2  (vv[1]),
    .vpu_valid_in_3  (vv[2]),
    .vpu_valid_in_4  (vv[3]),
    .ub              (ub.master),
    .wb_busy         (wb_busy),
    .wb_done         (wb_done),
    .wb_overflow_err (wb_overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  first_valid_cyc = -1;
  int  cyc_l4 = 0;
  bit  arm_first = 1'b0;
  int  ready_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: never ready
  wr_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ub.ub_wr_ready = 1'b1;
      1:       ub.ub_wr_ready = (cyc % 3 == 0);
      default: ub.ub_wr_ready = 1'b0;
    endcase
  endtask

  function automatic elem_t elem(input logic [7:0] seed, input int row, input int lane);
    return elem_t'({seed, 4'(row), 4'(lane + 1)});
  endfunction

  task automatic idle_lanes();
    for (int k = 0; k < LANES; k++) begin
      vv[k] = 1'b0;
      vd[k] = '0;
    end
  endtask

  // Step t of a skewed feed of n rows: lane k carries row t-k.
  task automatic drive_step(input int t, input int n, input logic [7:0] seed,
                            input logic [3:0] mask);
    for (int k = 0; k < LANES; k++) begin
      int r;
      r = t - k;
      if (mask[k] && r >= 0 && r < n) begin
        vv[k] = 1'b1;
        vd[k] = elem(seed, r, k);
      end else begin
        vv[k] = 1'b0;
        vd[k] = '0;
      end
    end
  endtask

  task automatic feed(input int n, input logic [7:0] seed);
    for (int t = 0; t < n + LANES - 1; t++) begin
      drive_step(t, n, seed, 4'hF);
      if (t == LANES - 1) cyc_l4 = cyc;
      tick();
    end
    idle_lanes();
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_row(input logic [ADDR_W-1:0] addr, input logic [7:0] seed, input int row);
    push_exp(addr, {elem(seed, row, 3), elem(seed, row, 2), elem(seed, row, 1), elem(seed, row, 0)});
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [ROW_W-1:0] rows);
    wb_start     = 1'b1;
    wb_base_addr = base;
    wb_num_rows  = rows;
    tick();
    wb_start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !wb_done; i++) tick();
    if (!wb_done) fail_now({name, "_done_timeout"});
    else          check({name, "_busy_at_done"}, 64'(wb_busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, 64'(ub.ub_wr_valid), 64'd0);
    check({name, "_addr"},  64'(ub.ub_wr_addr),  64'd0);
    check({name, "_data"},  ub.ub_wr_data,       64'd0);
    check({name, "_busy"},  64'(wb_busy),        64'd0);
    check({name, "_done"},  64'(wb_done),        64'd0);
    check({name, "_ovf"},   64'(wb_overflow_err), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks that a stalled
  // word holds still, and counts done pulses.
  initial begin
    logic              held_v;
    logic [ADDR_W-1:0] held_addr;
    logic [WORD_W-1:0] held_data;
    wr_t               e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (ub.ub_wr_valid) begin
          if (arm_first) begin
            first_valid_cyc = cyc;
            arm_first       = 1'b0;
          end
          if (held_v) begin
            check("stall_addr", 64'(ub.ub_wr_addr), 64'(held_addr));
            check("stall_data", ub.ub_wr_data, held_data);
          end
          if (ub.ub_wr_ready) begin
            held_v = 1'b0;
            wr_cnt++;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                       ub.ub_wr_addr, ub.ub_wr_data);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", 64'(ub.ub_wr_addr), 64'(e.addr));
              check("wr_data", ub.ub_wr_data, e.data);
            end
          end else begin
            held_v    = 1'b1;
            held_addr = ub.ub_wr_addr;
            held_data = ub.ub_wr_data;
          end
        end else if (held_v) begin
          held_v = 1'b0;
          fail_now("valid_dropped_while_stalled");
        end
        if (wb_done) done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int  d0;
    int  w0;
    bit  hit;

    rst            = 1'b1;
    wb_start       = 1'b0;
    wb_base_addr   = '0;
    wb_num_rows    = '0;
    ub.ub_wr_ready = 1'b1;
    idle_lanes();
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // 1. Basic run, hand-computed words.
    push_exp(10'h010, 64'hA104_A103_A102_A101);
    push_exp(10'h011, 64'hA114_A113_A112_A111);
    push_exp(10'h012, 64'hA124_A123_A122_A121);
    push_exp(10'h013, 64'hA134_A133_A132_A131);
    d0 = done_cnt;
    start(10'h010, 8'd4);
    check("t1_busy", 64'(wb_busy), 64'd1);
    arm_first = 1'b1;
    feed(4, 8'hA1);
    wait_done("t1", 50);
    tick();
    check("t1_done_pulse_width", 64'(wb_done), 64'd0);
    tick();
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_latency", 64'(first_valid_cyc), 64'(cyc_l4 + 2));
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // 2. Backpressure with ready 1,0,0,...
    ready_mode = 1;
    d0 = done_cnt;
    for (int r = 0; r < 8; r++) push_row(10'h040 + 10'(r), 8'hF0, r);
    start(10'h040, 8'd8);
    feed(8, 8'hF0);
    wait_done("t2", 200);
    ready_mode = 0;
    tick();
    tick();
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);
    check("t2_overflow", 64'(wb_overflow_err), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3. Overflow: lane 4 silent so nothing pops; lane 1 fills first.
    ready_mode = 2;
    start(10'h000, 8'd1);
    for (int t = 0; t < 11; t++) begin
      drive_step(t, 9, 8'h90, 4'b0111);
      tick();
      if (t == 7) check("t3_ovf_after_8", 64'(wb_overflow_err), 64'd0);
      if (t == 8) check("t3_ovf_after_9", 64'(wb_overflow_err), 64'd1);
    end
    idle_lanes();
    repeat (3) tick();
    check("t3_ovf_sticky", 64'(wb_overflow_err), 64'd1);
    rst = 1'b1;
    tick();
    check("t3_ovf_cleared", 64'(wb_overflow_err), 64'd0);
    check("t3_busy_cleared", 64'(wb_busy), 64'd0);
    rst        = 1'b0;
    ready_mode = 0;
    tick();

    // 4a. Zero-row command.
    w0 = wr_cnt;
    d0 = done_cnt;
    start(10'h055, 8'd0);
    check("t4a_done", 64'(wb_done), 64'd1);
    check("t4a_busy", 64'(wb_busy), 64'd0);
    tick();
    check("t4a_done_pulse_width", 64'(wb_done), 64'd0);
    repeat (3) tick();
    check("t4a_no_write", 64'(wr_cnt - w0), 64'd0);
    check("t4a_done_count", 64'(done_cnt - d0), 64'd1);

    // 4b. Start during RUN ignored; one surplus row fed and discarded.
    d0 = done_cnt;
    for (int r = 0; r < 3; r++) push_row(10'h100 + 10'(r), 8'h7E, r);
    start(10'h100, 8'd3);
    start(10'h200, 8'd5);
    feed(4, 8'h7E);
    wait_done("t4b", 50);
    repeat (2) tick();
    check("t4b_done_count", 64'(done_cnt - d0), 64'd1);
    check("t4b_overflow", 64'(wb_overflow_err), 64'd0);
    check("t4b_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5. Address wrap.
    push_exp(10'h3FE, 64'h3C04_3C03_3C02_3C01);
    push_exp(10'h3FF, 64'h3C14_3C13_3C12_3C11);
    push_exp(10'h000, 64'h3C24_3C23_3C22_3C21);
    push_exp(10'h001, 64'h3C34_3C33_3C32_3C31);
    start(10'h3FE, 8'd4);
    feed(4, 8'h3C);
    wait_done("t5", 50);
    repeat (2) tick();
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6. Reset after two of six rows, then a fresh two-row run.
    for (int r = 0; r < 6; r++) push_row(10'h020 + 10'(r), 8'h66, r);
    w0  = wr_cnt;
    d0  = done_cnt;
    hit = 1'b0;
    start(10'h020, 8'd6);
    for (int t = 0; t < 6 + LANES - 1 && !hit; t++) begin
      drive_step(t, 6, 8'h66, 4'hF);
      tick();
      if (wr_cnt - w0 == 2) hit = 1'b1;
    end
    if (!hit) fail_now("t6_two_writes_timeout");
    rst = 1'b1;
    idle_lanes();
    exp_q.delete();
    tick();
    check_outputs_zero("t6_after_rst");
    rst = 1'b0;
    repeat (5) tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_writes_before_rst", 64'(wr_cnt - w0), 64'd2);
    d0 = done_cnt;
    push_row(10'h030, 8'h22, 0);
    push_row(10'h031, 8'h22, 1);
    start(10'h030, 8'd2);
    feed(2, 8'h22);
    wait_done("t6_fresh", 50);
    repeat (2) tick();
    check("t6_fresh_done_count", 64'(done_cnt - d0), 64'd1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
